csr_trap_seq: RTL and testbench

//  Sequencer and arbiter for the machine-mode CSR register file. It takes three kinds of request:

---
 rtl/csr_trap_seq_if.sv | 35 +++
 rtl/csr_trap_seq.sv | 185 ++++++++++++++++++
 tb/tb_csr_trap_seq.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_trap_seq_if.sv
// Request/response handshake between the pipeline and the machine-mode CSR trap sequencer.
// The slave modport is the sequencer's view; the master modport is the requester's view.
interface csr_trap_seq_if #(
   parameter int XLEN = 32
) ();
   logic            trap_req_i;
   logic [XLEN-1:0] trap_cause_i;
   logic [XLEN-1:0] trap_pc_i;
   logic            mret_req_i;
   logic            csr_req_i;
   logic            csr_we_i;
   logic [11:0]     csr_addr_i;
   logic [XLEN-1:0] csr_wdata_i;
   logic            csr_ready_o;
   logic [XLEN-1:0] csr_rdata_o;
   logic            csr_illegal_o;
   logic            trap_ack_o;
   logic            redirect_o;
   logic [XLEN-1:0] redirect_pc_o;
   logic            busy_o;

   modport slave (
      input  trap_req_i, trap_cause_i, trap_pc_i, mret_req_i,
      input  csr_req_i, csr_we_i, csr_addr_i, csr_wdata_i,
      output csr_ready_o, csr_rdata_o, csr_illegal_o,
      output trap_ack_o, redirect_o, redirect_pc_o, busy_o
   );

   modport master (
      output trap_req_i, trap_cause_i, trap_pc_i, mret_req_i,
      output csr_req_i, csr_we_i, csr_addr_i, csr_wdata_i,
      input  csr_ready_o, csr_rdata_o, csr_illegal_o,
      input  trap_ack_o, redirect_o, redirect_pc_o, busy_o
   );
endinterface

// File: rtl/csr_trap_seq.sv
// Machine-mode CSR sequencer: arbitrates trap entry, mret and CSR-instruction access and turns
// each into a fixed strobe sequence on a single-port CSR file with 1-cycle registered read data.
//
// state    | meaning
// S_IDLE   | waiting; requests sampled here, priority trap > mret > csr
// T_RDST   | trap: read mstatus
// T_WEPC   | trap: capture mstatus, write mepc
// T_WCAUSE | trap: write mcause
// T_WST    | trap: write updated mstatus (MPIE<=MIE, MIE<=0, MPP<=3)
// T_RVEC   | trap: read mtvec
// T_DONE   | trap: pulse trap_ack/redirect with vector PC
// M_RDST   | mret: read mstatus
// M_WST    | mret: write updated mstatus (MIE<=MPIE, MPIE<=1, MPP<=3)
// M_REPC   | mret: read mepc
// M_DONE   | mret: pulse redirect with mepc
// C_ACC    | csr: single read or write strobe
// C_RESP   | csr: pulse csr_ready (and csr_illegal for read-only writes)
module csr_trap_seq #(
   parameter int XLEN   = 32,
   parameter bit VEC_EN = 1'b1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   csr_trap_seq_if.slave   bus,
   output logic [31:0]     csr_addr_o,
   output logic            csr_en_write_o,
   output logic            csr_en_read_o,
   output logic [XLEN-1:0] csr_data_o,
   input  logic [XLEN-1:0] csr_data_i
);

   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MTVEC   = 12'h305;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

   typedef enum logic [3:0] {
      S_IDLE, T_RDST, T_WEPC, T_WCAUSE, T_WST, T_RVEC, T_DONE,
      M_RDST, M_WST, M_REPC, M_DONE, C_ACC, C_RESP
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] cause_q, epc_q, mstatus_q, cwdata_q;
   logic [11:0]     caddr_q;
   logic            cwe_q;
   logic [11:0]     addr_q, addr_d;
   logic            rd_q, rd_d, wr_q, wr_d;
   logic            ready_q, ill_q, ack_q, redir_q, busy_q;
   logic [XLEN-1:0] data_mux, pc_mux, rdata_mux;
   logic [XLEN-1:0] trap_ms, mret_ms, vec_base;
   logic            vec_mode;
   logic            c_ro;

   assign c_ro = (caddr_q[11:10] == 2'b11);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.trap_req_i)      state_d = T_RDST;
            else if (bus.mret_req_i) state_d = M_RDST;
            else if (bus.csr_req_i)  state_d = C_ACC;
         end
         T_RDST:   state_d = T_WEPC;
         T_WEPC:   state_d = T_WCAUSE;
         T_WCAUSE: state_d = T_WST;
         T_WST:    state_d = T_RVEC;
         T_RVEC:   state_d = T_DONE;
         T_DONE:   state_d = S_IDLE;
         M_RDST:   state_d = M_WST;
         M_WST:    state_d = M_REPC;
         M_REPC:   state_d = M_DONE;
         M_DONE:   state_d = S_IDLE;
         C_ACC:    state_d = C_RESP;
         C_RESP:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Strobes are decoded from the next state so they appear registered in the state they belong to.
   always_comb begin
      rd_d   = 1'b0;
      wr_d   = 1'b0;
      addr_d = '0;
      unique case (state_d)
         T_RDST, M_RDST: begin rd_d = 1'b1; addr_d = ADDR_MSTATUS; end
         T_WEPC:         begin wr_d = 1'b1; addr_d = ADDR_MEPC;    end
         T_WCAUSE:       begin wr_d = 1'b1; addr_d = ADDR_MCAUSE;  end
         T_WST, M_WST:   begin wr_d = 1'b1; addr_d = ADDR_MSTATUS; end
         T_RVEC:         begin rd_d = 1'b1; addr_d = ADDR_MTVEC;   end
         M_REPC:         begin rd_d = 1'b1; addr_d = ADDR_MEPC;    end
         C_ACC: begin
            addr_d = bus.csr_addr_i;
            if (!bus.csr_we_i)                        rd_d = 1'b1;
            else if (bus.csr_addr_i[11:10] != 2'b11)  wr_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         cause_q   <= '0;
         epc_q     <= '0;
         mstatus_q <= '0;
         cwdata_q  <= '0;
         caddr_q   <= '0;
         cwe_q     <= 1'b0;
         addr_q    <= '0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         ready_q   <= 1'b0;
         ill_q     <= 1'b0;
         ack_q     <= 1'b0;
         redir_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         // Request payloads are held by the requester, so capturing every idle cycle is safe.
         if (state_q == S_IDLE) begin
            cause_q  <= bus.trap_cause_i;
            epc_q    <= bus.trap_pc_i & ~XLEN'(3);
            cwe_q    <= bus.csr_we_i;
            caddr_q  <= bus.csr_addr_i;
            cwdata_q <= bus.csr_wdata_i;
         end
         if (state_q == T_WEPC) mstatus_q <= csr_data_i;
         addr_q  <= addr_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         ready_q <= (state_d == C_RESP);
         ill_q   <= (state_d == C_RESP) && cwe_q && c_ro;
         ack_q   <= (state_d == T_DONE);
         redir_q <= (state_d == T_DONE) || (state_d == M_DONE);
         busy_q  <= (state_d != S_IDLE);
      end
   end

   always_comb begin
      trap_ms     = mstatus_q;
      trap_ms[7]  = mstatus_q[3];
      trap_ms[3]  = 1'b0;
      trap_ms[12:11] = 2'b11;
      mret_ms     = csr_data_i;
      mret_ms[3]  = csr_data_i[7];
      mret_ms[7]  = 1'b1;
      mret_ms[12:11] = 2'b11;
   end

   assign vec_base = csr_data_i & ~XLEN'(3);
   assign vec_mode = VEC_EN && (csr_data_i[1:0] == 2'b01) && cause_q[XLEN-1];

   // Data paths that depend on read data are muxed live: the CSR file answers in the same cycle they are needed.
   always_comb begin
      data_mux  = '0;
      pc_mux    = '0;
      rdata_mux = '0;
      unique case (state_q)
         T_WEPC:   data_mux = epc_q;
         T_WCAUSE: data_mux = cause_q;
         T_WST:    data_mux = trap_ms;
         M_WST:    data_mux = mret_ms;
         C_ACC:    if (cwe_q && !c_ro) data_mux = cwdata_q;
         T_DONE:   pc_mux = vec_mode ? vec_base + {cause_q[XLEN-3:0], 2'b00} : vec_base;
         M_DONE:   pc_mux = vec_base;
         C_RESP:   if (!cwe_q) rdata_mux = csr_data_i;
         default: ;
      endcase
   end

   assign csr_addr_o     = {20'b0, addr_q};
   assign csr_en_read_o  = rd_q;
   assign csr_en_write_o = wr_q;
   assign csr_data_o     = data_mux;

   assign bus.csr_ready_o   = ready_q;
   assign bus.csr_rdata_o   = rdata_mux;
   assign bus.csr_illegal_o = ill_q;
   assign bus.trap_ack_o    = ack_q;
   assign bus.redirect_o    = redir_q;
   assign bus.redirect_pc_o = pc_mux;
   assign bus.busy_o        = busy_q;

endmodule

// File: tb/tb_csr_trap_seq.sv
// Scoreboard bench for csr_trap_seq: two instances (vectored mode enabled/disabled) share one
// stimulus stream, each backed by its own CSR file model.
module tb_csr_trap_seq;

   localparam logic [31:0] K_CSR  = 32'd0;
   localparam logic [31:0] K_TRAP = 32'd1;
   localparam logic [31:0] K_MRET = 32'd2;

   typedef struct {
      logic [31:0] kind;
      logic [31:0] val;
      logic [31:0] val0;
      logic        ill;
   } exp_t;

   logic clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   logic        rst = 1'b1;
   logic        trap_req = 1'b0, mret_req = 1'b0, csr_req = 1'b0, csr_we = 1'b0;
   logic [31:0] trap_cause = '0, trap_pc = '0, csr_wdata = '0;
   logic [11:0] csr_addr = '0;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];
   exp_t mon_e;

   csr_trap_seq_if #(.XLEN(32)) if0 ();
   csr_trap_seq_if #(.XLEN(32)) if1 ();

   assign if0.trap_req_i = trap_req;   assign if1.trap_req_i = trap_req;
   assign if0.trap_cause_i = trap_cause; assign if1.trap_cause_i = trap_cause;
   assign if0.trap_pc_i = trap_pc;     assign if1.trap_pc_i = trap_pc;
   assign if0.mret_req_i = mret_req;   assign if1.mret_req_i = mret_req;
   assign if0.csr_req_i = csr_req;     assign if1.csr_req_i = csr_req;
   assign if0.csr_we_i = csr_we;       assign if1.csr_we_i = csr_we;
   assign if0.csr_addr_i = csr_addr;   assign if1.csr_addr_i = csr_addr;
   assign if0.csr_wdata_i = csr_wdata; assign if1.csr_wdata_i = csr_wdata;

   logic [31:0] a0, a1, d0, d1;
   logic [31:0] q0 = '0, q1 = '0;
   logic        r0, r1, w0, w1;
   logic [31:0] mem0 [4096];
   logic [31:0] mem1 [4096];

   csr_trap_seq #(.XLEN(32), .VEC_EN(1'b1)) dut0 (
      .clk_i(clk_sys), .rst_i(rst), .bus(if0.slave),
      .csr_addr_o(a0), .csr_en_write_o(w0), .csr_en_read_o(r0),
      .csr_data_o(d0), .csr_data_i(q0)
   );

   csr_trap_seq #(.XLEN(32), .VEC_EN(1'b0)) dut1 (
      .clk_i(clk_sys), .rst_i(rst), .bus(if1.slave),
      .csr_addr_o(a1), .csr_en_write_o(w1), .csr_en_read_o(r1),
      .csr_data_o(d1), .csr_data_i(q1)
   );

   always @(posedge clk_sys) begin
      if (w0) mem0[a0[11:0]] <= d0;
      if (r0) q0 <= mem0[a0[11:0]];
      if (w1) mem1[a1[11:0]] <= d1;
      if (r1) q1 <= mem1[a1[11:0]];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk_sys) begin
      if (!rst) begin
         if (r0 || w0) begin
            chk("one_strobe", 32'(r0 & w0), 32'd0);
            chk("addr_hi", 32'(a0[31:12]), 32'd0);
         end
         if (w0) chk("ro_write", 32'(a0[11:10] == 2'b11), 32'd0);
         if (r1 || w1) chk("addr_hi_v0", 32'(a1[31:12]), 32'd0);
         if (if0.csr_ready_o) begin
            if (sb.size() == 0) chk("sb_underflow_csr", 32'd1, 32'd0);
            else begin
               mon_e = sb.pop_front();
               chk("kind_csr", K_CSR, mon_e.kind);
               chk("rdata", if0.csr_rdata_o, mon_e.val);
               chk("illegal", 32'(if0.csr_illegal_o), 32'(mon_e.ill));
               chk("rdata_v0", if1.csr_rdata_o, mon_e.val0);
            end
         end
         if (if0.redirect_o) begin
            if (sb.size() == 0) chk("sb_underflow_redir", 32'd1, 32'd0);
            else begin
               mon_e = sb.pop_front();
               chk("redir_kind_is_csr", 32'(mon_e.kind == K_CSR), 32'd0);
               chk("trap_ack", 32'(if0.trap_ack_o), 32'(mon_e.kind == K_TRAP));
               chk("redirect_pc", if0.redirect_pc_o, mon_e.val);
               chk("redirect_v0", 32'(if1.redirect_o), 32'd1);
               chk("redirect_pc_v0", if1.redirect_pc_o, mon_e.val0);
            end
         end else begin
            if (if0.trap_ack_o) chk("ack_without_redirect", 32'd1, 32'd0);
         end
      end
   end

   // sel: 0 = csr_ready, 1 = redirect, 2 = trap_ack
   task automatic wait_for(input int sel, input string tag, output int cnt);
      bit got = 1'b0;
      cnt = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk_sys);
         cnt++;
         if ((sel == 0 && if0.csr_ready_o) || (sel == 1 && if0.redirect_o) ||
             (sel == 2 && if0.trap_ack_o)) got = 1'b1;
      end
      if (!got) chk({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic push(input logic [31:0] kind, input logic [31:0] v, input logic [31:0] v0,
                       input logic ill);
      exp_t e;
      e.kind = kind; e.val = v; e.val0 = v0; e.ill = ill;
      sb.push_back(e);
   endtask

   task automatic do_csr(input logic we, input logic [11:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_ill);
      int cnt;
      @(negedge clk_sys);
      csr_req = 1'b1; csr_we = we; csr_addr = addr; csr_wdata = wd;
      push(K_CSR, exp_rd, exp_rd, exp_ill);
      wait_for(0, "csr", cnt);
      csr_req = 1'b0;
   endtask

   task automatic do_trap(input logic [31:0] cause, input logic [31:0] pc,
                          input logic [31:0] exp_pc, input logic [31:0] exp_pc0, input int lat);
      int cnt;
      @(negedge clk_sys);
      trap_req = 1'b1; trap_cause = cause; trap_pc = pc;
      push(K_TRAP, exp_pc, exp_pc0, 1'b0);
      wait_for(1, "trap", cnt);
      if (lat > 0) chk("trap_latency", 32'(cnt), 32'(lat));
      trap_req = 1'b0;
   endtask

   task automatic do_mret(input logic [31:0] exp_pc, input int lat);
      int cnt;
      @(negedge clk_sys);
      mret_req = 1'b1;
      push(K_MRET, exp_pc, exp_pc, 1'b0);
      wait_for(1, "mret", cnt);
      if (lat > 0) chk("mret_latency", 32'(cnt), 32'(lat));
      mret_req = 1'b0;
   endtask

   initial begin
      int cnt;
      bit hit;
      repeat (3) @(negedge clk_sys);
      chk("rst_busy", 32'(if0.busy_o), 32'd0);
      chk("rst_ready", 32'(if0.csr_ready_o), 32'd0);
      chk("rst_ack", 32'(if0.trap_ack_o), 32'd0);
      chk("rst_redirect", 32'(if0.redirect_o), 32'd0);
      chk("rst_strobes", 32'({r0, w0}), 32'd0);
      chk("rst_addr", a0, 32'd0);
      chk("rst_wdata", d0, 32'd0);
      chk("rst_pc", if0.redirect_pc_o, 32'd0);
      rst = 1'b0;

      // basic trap entry in direct mode
      do_csr(1'b1, 12'h305, 32'h0000_1000, 32'd0, 1'b0);
      do_csr(1'b1, 12'h300, 32'h0000_0008, 32'd0, 1'b0);
      do_trap(32'd2, 32'h0000_2006, 32'h1000, 32'h1000, 6);
      do_csr(1'b0, 12'h341, 32'd0, 32'h2004, 1'b0);
      do_csr(1'b0, 12'h342, 32'd0, 32'd2, 1'b0);
      do_csr(1'b0, 12'h300, 32'd0, 32'h1880, 1'b0);

      // vectored interrupt, wraparound, reserved mode
      do_csr(1'b1, 12'h305, 32'h0000_1001, 32'd0, 1'b0);
      do_trap(32'h8000_0007, 32'h2100, 32'h101C, 32'h1000, 6);
      do_csr(1'b0, 12'h300, 32'd0, 32'h1800, 1'b0);
      do_csr(1'b0, 12'h341, 32'd0, 32'h2100, 1'b0);
      do_csr(1'b1, 12'h305, 32'hFFFF_FFF1, 32'd0, 1'b0);
      do_trap(32'h8000_0005, 32'h5000, 32'h0000_0004, 32'hFFFF_FFF0, 0);
      do_csr(1'b1, 12'h305, 32'h0000_1003, 32'd0, 1'b0);
      do_trap(32'h8000_0001, 32'h5004, 32'h1000, 32'h1000, 0);

      // mret
      do_csr(1'b1, 12'h300, 32'h0000_1880, 32'd0, 1'b0);
      do_csr(1'b1, 12'h341, 32'h0000_2004, 32'd0, 1'b0);
      do_mret(32'h2004, 4);
      do_csr(1'b0, 12'h300, 32'd0, 32'h1888, 1'b0);
      do_csr(1'b1, 12'h341, 32'h0000_2007, 32'd0, 1'b0);
      do_mret(32'h2004, 4);

      // simultaneous requests: trap, then mret, then csr read
      do_csr(1'b1, 12'h305, 32'h0000_1001, 32'd0, 1'b0);
      @(negedge clk_sys);
      trap_req = 1'b1; trap_cause = 32'd3; trap_pc = 32'h3000;
      mret_req = 1'b1;
      csr_req = 1'b1; csr_we = 1'b0; csr_addr = 12'h342; csr_wdata = '0;
      push(K_TRAP, 32'h1000, 32'h1000, 1'b0);
      push(K_MRET, 32'h3000, 32'h3000, 1'b0);
      push(K_CSR, 32'd3, 32'd3, 1'b0);
      wait_for(2, "arb_trap", cnt);
      trap_req = 1'b0;
      wait_for(1, "arb_mret", cnt);
      chk("arb_csr_waits", 32'(if0.csr_ready_o), 32'd0);
      mret_req = 1'b0;
      wait_for(0, "arb_csr", cnt);
      csr_req = 1'b0;

      // read-only write and write/read-back
      do_csr(1'b1, 12'hF11, 32'h0000_DEAD, 32'd0, 1'b1);
      do_csr(1'b1, 12'h305, 32'h0000_1001, 32'd0, 1'b0);
      do_csr(1'b0, 12'h305, 32'd0, 32'h1001, 1'b0);

      // reset in the middle of trap entry
      @(negedge clk_sys);
      trap_req = 1'b1; trap_cause = 32'd9; trap_pc = 32'h4446;
      hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
         @(negedge clk_sys);
         if (w0 && a0 == 32'h342) hit = 1'b1;
      end
      chk("reach_wcause", 32'(hit), 32'd1);
      rst = 1'b1;
      trap_req = 1'b0;
      @(negedge clk_sys);
      chk("mid_rst_busy", 32'(if0.busy_o), 32'd0);
      chk("mid_rst_ack", 32'(if0.trap_ack_o), 32'd0);
      chk("mid_rst_redirect", 32'(if0.redirect_o), 32'd0);
      chk("mid_rst_strobes", 32'({r0, w0}), 32'd0);
      rst = 1'b0;
      repeat (8) @(negedge clk_sys);
      do_csr(1'b0, 12'h341, 32'd0, 32'h4444, 1'b0);

      repeat (3) @(negedge clk_sys);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
